// File: rtl/sdram_responder.sv
// sdram_responder: behavioural SDRAM device model. Decodes the command bus,
// tracks the open row of each bank, runs read/write bursts against a local
// word store and raises a sticky error flag on protocol violations.
//
// state        | meaning
// BANK_IDLE    | bank precharged, no row open
// BANK_ACTIVE  | row latched; READ/WRITE allowed once the tRCD timer expires
// BURST_IDLE   | no burst beats pending
// BURST_READ   | issuing read beats into the CAS-latency pipeline
// BURST_WRITE  | capturing write beats from dq_in
module sdram_responder #(
  parameter int MEM_AW = 12,
  parameter int TRCD   = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        SDRAM_nCS,
  input  logic        SDRAM_nRAS,
  input  logic        SDRAM_nCAS,
  input  logic        SDRAM_nWE,
  input  logic [12:0] SDRAM_A,
  input  logic [1:0]  SDRAM_BA,
  input  logic        SDRAM_DQML,
  input  logic        SDRAM_DQMH,
  input  logic [15:0] dq_in,
  output logic [15:0] dq_out,
  output logic        dq_oe,
  output logic        err,
  output logic [15:0] refresh_cnt
);

  // tRCD timer is a down-counter; READ/WRITE is legal once it reaches zero.
  localparam logic [7:0] TRCD_LOAD = (TRCD > 0) ? 8'(TRCD - 1) : 8'd0;

  typedef enum logic {BANK_IDLE, BANK_ACTIVE} bank_state_t;
  typedef enum logic [1:0] {BURST_IDLE, BURST_READ, BURST_WRITE} burst_state_t;

  bank_state_t  bank_st  [4];
  logic [12:0]  bank_row [4];
  logic [7:0]   trcd_cnt [4];

  logic         mode_valid;
  logic [1:0]   bl_code;
  logic         cl3;
  logic         wb_single;

  burst_state_t burst_st;
  logic [1:0]   burst_bank;
  logic [12:0]  burst_row;
  logic [8:0]   burst_col;
  logic [3:0]   burst_left;
  logic         burst_ap;

  logic         s0_valid, s1_valid;
  logic [15:0]  s0_data, s1_data;
  logic         dqm_q;

  logic [15:0]  mem [2**MEM_AW];

  logic [3:0]   cmd;
  logic         cmd_act, cmd_rd, cmd_wr, cmd_bt, cmd_pre, cmd_ref, cmd_lmr;
  logic         any_active, sel_active;
  logic         rw_cmd, rw_ok, act_ok, lmr_ok, ref_ok, viol;
  logic         in_burst, stop_burst;
  logic [3:0]   bl_len, rw_len;
  logic [8:0]   bl_mask;
  logic         beat_valid, beat_write, beat_last, beat_ap;
  logic [1:0]   beat_bank;
  logic [12:0]  beat_row;
  logic [8:0]   beat_col;
  logic [MEM_AW-1:0] beat_idx;
  logic [15:0]  rd_word;
  logic         out_valid;
  logic [15:0]  out_data;

  // Sequential column increment that wraps inside the burst-aligned block.
  function automatic logic [8:0] next_col(input logic [8:0] c, input logic [8:0] m);
    return (c & ~m) | ((c + 9'd1) & m);
  endfunction

  // Command decode, legality checks and selection of this cycle's burst beat.
  always_comb begin
    cmd     = {SDRAM_nCS, SDRAM_nRAS, SDRAM_nCAS, SDRAM_nWE};
    cmd_act = (cmd == 4'b0011);
    cmd_rd  = (cmd == 4'b0101);
    cmd_wr  = (cmd == 4'b0100);
    cmd_bt  = (cmd == 4'b0110);
    cmd_pre = (cmd == 4'b0010);
    cmd_ref = (cmd == 4'b0001);
    cmd_lmr = (cmd == 4'b0000);

    any_active = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (bank_st[i] == BANK_ACTIVE) any_active = 1'b1;
    end
    sel_active = (bank_st[SDRAM_BA] == BANK_ACTIVE);

    bl_len  = 4'd1 << bl_code;
    bl_mask = 9'(bl_len - 4'd1);

    rw_cmd = cmd_rd | cmd_wr;
    rw_ok  = rw_cmd && mode_valid && sel_active && (trcd_cnt[SDRAM_BA] == 8'd0);
    act_ok = cmd_act && mode_valid && !sel_active;
    lmr_ok = cmd_lmr && !SDRAM_A[2] &&
             ((SDRAM_A[6:4] == 3'd2) || (SDRAM_A[6:4] == 3'd3)) && !any_active;
    ref_ok = cmd_ref && !any_active;
    viol   = (cmd_act && !act_ok) || (rw_cmd && !rw_ok) ||
             (cmd_lmr && !lmr_ok) || (cmd_ref && !ref_ok);

    rw_len     = (cmd_wr && wb_single) ? 4'd1 : bl_len;
    in_burst   = (burst_st != BURST_IDLE);
    stop_burst = in_burst && (rw_ok || cmd_bt ||
                 (cmd_pre && (SDRAM_A[10] || (SDRAM_BA == burst_bank))));

    beat_valid = 1'b0;
    beat_write = 1'b0;
    beat_last  = 1'b0;
    beat_ap    = 1'b0;
    beat_bank  = 2'd0;
    beat_row   = 13'd0;
    beat_col   = 9'd0;
    if (rw_ok) begin
      beat_valid = 1'b1;
      beat_write = cmd_wr;
      beat_last  = (rw_len == 4'd1);
      beat_ap    = SDRAM_A[10];
      beat_bank  = SDRAM_BA;
      beat_row   = bank_row[SDRAM_BA];
      beat_col   = SDRAM_A[8:0];
    end else if (in_burst && !stop_burst) begin
      beat_valid = 1'b1;
      beat_write = (burst_st == BURST_WRITE);
      beat_last  = (burst_left == 4'd1);
      beat_ap    = burst_ap;
      beat_bank  = burst_bank;
      beat_row   = burst_row;
      beat_col   = burst_col;
    end
    beat_idx = MEM_AW'({beat_bank, beat_row, beat_col});
    rd_word  = mem[beat_idx];

    out_valid = cl3 ? s1_valid : s0_valid;
    out_data  = cl3 ? s1_data  : s0_data;
  end

  // Backing store; byte lanes written unless masked. Contents survive reset.
  always_ff @(posedge clk) begin
    if (beat_valid && beat_write) begin
      if (!SDRAM_DQML) mem[beat_idx][7:0]  <= dq_in[7:0];
      if (!SDRAM_DQMH) mem[beat_idx][15:8] <= dq_in[15:8];
    end
  end

  // Bank, mode, burst, CAS pipeline and status state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 4; i++) begin
        bank_st[i]  <= BANK_IDLE;
        bank_row[i] <= 13'd0;
        trcd_cnt[i] <= 8'd0;
      end
      mode_valid  <= 1'b0;
      bl_code     <= 2'd0;
      cl3         <= 1'b0;
      wb_single   <= 1'b0;
      burst_st    <= BURST_IDLE;
      burst_bank  <= 2'd0;
      burst_row   <= 13'd0;
      burst_col   <= 9'd0;
      burst_left  <= 4'd0;
      burst_ap    <= 1'b0;
      s0_valid    <= 1'b0;
      s0_data     <= 16'd0;
      s1_valid    <= 1'b0;
      s1_data     <= 16'd0;
      dqm_q       <= 1'b0;
      dq_oe       <= 1'b0;
      dq_out      <= 16'd0;
      err         <= 1'b0;
      refresh_cnt <= 16'd0;
    end else begin
      if (viol) err <= 1'b1;
      if (ref_ok) refresh_cnt <= refresh_cnt + 16'd1;

      if (lmr_ok) begin
        mode_valid <= 1'b1;
        bl_code    <= SDRAM_A[1:0];
        cl3        <= SDRAM_A[4];
        wb_single  <= SDRAM_A[9];
      end

      for (int i = 0; i < 4; i++) begin
        if (trcd_cnt[i] != 8'd0) trcd_cnt[i] <= trcd_cnt[i] - 8'd1;
        if (cmd_pre && (SDRAM_A[10] || (SDRAM_BA == 2'(i)))) bank_st[i] <= BANK_IDLE;
      end
      if (beat_valid && beat_last && beat_ap) bank_st[beat_bank] <= BANK_IDLE;
      if (act_ok) begin
        bank_st[SDRAM_BA]  <= BANK_ACTIVE;
        bank_row[SDRAM_BA] <= SDRAM_A;
        trcd_cnt[SDRAM_BA] <= TRCD_LOAD;
      end

      if (rw_ok) begin
        if (rw_len == 4'd1) begin
          burst_st <= BURST_IDLE;
        end else begin
          burst_st   <= cmd_wr ? BURST_WRITE : BURST_READ;
          burst_bank <= SDRAM_BA;
          burst_row  <= bank_row[SDRAM_BA];
          burst_col  <= next_col(SDRAM_A[8:0], bl_mask);
          burst_left <= rw_len - 4'd1;
          burst_ap   <= SDRAM_A[10];
        end
      end else if (stop_burst) begin
        burst_st <= BURST_IDLE;
      end else if (in_burst) begin
        burst_col  <= next_col(burst_col, bl_mask);
        burst_left <= burst_left - 4'd1;
        if (burst_left == 4'd1) burst_st <= BURST_IDLE;
      end

      // Read DQM acts on the word loaded into dq_out on the following edge.
      dqm_q    <= SDRAM_DQML | SDRAM_DQMH;
      s0_valid <= beat_valid && !beat_write;
      s0_data  <= rd_word;
      s1_valid <= s0_valid;
      s1_data  <= s0_data;
      dq_oe    <= out_valid && !dqm_q;
      dq_out   <= out_valid ? out_data : 16'd0;
    end
  end

endmodule

// File: tb/tb_sdram_responder.sv
// Testbench for sdram_responder: directed protocol scenarios plus randomized
// read/write bursts checked by a queue-based scoreboard against a word-store model.
`timescale 1ns/1ps
module tb_sdram_responder;

  localparam int MEM_AW = 12;
  localparam int TRCD   = 2;

  localparam logic [3:0] C_NOP = 4'b0111;
  localparam logic [3:0] C_ACT = 4'b0011;
  localparam logic [3:0] C_RD  = 4'b0101;
  localparam logic [3:0] C_WR  = 4'b0100;
  localparam logic [3:0] C_BT  = 4'b0110;
  localparam logic [3:0] C_PRE = 4'b0010;
  localparam logic [3:0] C_REF = 4'b0001;
  localparam logic [3:0] C_LMR = 4'b0000;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        nCS = 1'b0, nRAS = 1'b1, nCAS = 1'b1, nWE = 1'b1;
  logic [12:0] A = '0;
  logic [1:0]  BA = '0;
  logic        DQML = 1'b0, DQMH = 1'b0;
  logic [15:0] dq_in = '0;
  logic [15:0] dq_out;
  logic        dq_oe;
  logic        err;
  logic [15:0] refresh_cnt;

  sdram_responder #(.MEM_AW(MEM_AW), .TRCD(TRCD)) dut (
    .clk(clk), .reset_n(reset_n),
    .SDRAM_nCS(nCS), .SDRAM_nRAS(nRAS), .SDRAM_nCAS(nCAS), .SDRAM_nWE(nWE),
    .SDRAM_A(A), .SDRAM_BA(BA), .SDRAM_DQML(DQML), .SDRAM_DQMH(DQMH),
    .dq_in(dq_in), .dq_out(dq_out), .dq_oe(dq_oe), .err(err),
    .refresh_cnt(refresh_cnt)
  );

  always #5 clk = ~clk;

  int edge_n = 0;
  always @(posedge clk) edge_n++;

  int tests = 0;
  int fails = 0;

  typedef struct { int due; logic [15:0] data; } exp_t;
  exp_t expq[$];
  bit   mask_at [int];
  bit   mon_en = 1'b0;
  logic [15:0] mm [int];

  int cur_bl = 1;
  int cur_cl = 2;
  bit cur_ws = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  function automatic int maddr(input int ba, input int row, input int col);
    return ((ba << 22) | (row << 9) | col) & ((1 << MEM_AW) - 1);
  endfunction

  function automatic int colseq(input int start, input int k);
    return (start - (start % cur_bl)) + ((start + k) % cur_bl);
  endfunction

  // One command cycle: inputs set after a falling edge, sampled at the next rising edge.
  task automatic drive(input logic [3:0] c, input logic [1:0] ba, input logic [12:0] a,
                       input logic ml, input logic mh, input logic [15:0] d);
    {nCS, nRAS, nCAS, nWE} = c;
    BA = ba; A = a; DQML = ml; DQMH = mh; dq_in = d;
    if (ml | mh) mask_at[edge_n + 3] = 1'b1;
    @(negedge clk);
  endtask

  task automatic nop(input int n);
    repeat (n) drive(C_NOP, 2'd0, 13'd0, 1'b0, 1'b0, 16'($urandom));
  endtask

  task automatic lmr(input int code, input int cl, input bit ws);
    drive(C_LMR, 2'd0, 13'((int'(ws) << 9) | (cl << 4) | code), 1'b0, 1'b0, 16'd0);
    cur_bl = 1 << code; cur_cl = cl; cur_ws = ws;
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    drive(C_NOP, 2'd0, 13'd0, 1'b0, 1'b0, 16'd0);
    reset_n = 1'b1;
    chk("reset_err", {31'd0, err}, 32'd0);
    chk("reset_refresh", {16'd0, refresh_cnt}, 32'd0);
  endtask

  task automatic model_wr(input int ad, input logic [15:0] d, input logic ml, input logic mh);
    logic [15:0] w;
    w = mm.exists(ad) ? mm[ad] : 16'd0;
    if (!ml) w[7:0]  = d[7:0];
    if (!mh) w[15:8] = d[15:8];
    mm[ad] = w;
  endtask

  task automatic do_read(input int ba, input int row, input int col, input bit ap, input bit rdqm);
    int e;
    logic m;
    e = edge_n + 1;
    for (int k = 0; k < cur_bl; k++)
      expq.push_back('{e + cur_cl + k, mm[maddr(ba, row, colseq(col, k))]});
    for (int k = 0; k < cur_bl + cur_cl + 1; k++) begin
      m = rdqm ? 1'($urandom_range(0, 3) == 0) : 1'b0;
      if (k == 0) drive(C_RD, 2'(ba), 13'((int'(ap) << 10) | col), m, m, 16'd0);
      else        drive(C_NOP, 2'd0, 13'd0, m, m, 16'd0);
    end
  endtask

  task automatic do_write(input int ba, input int row, input int col, input bit ap);
    int len;
    logic [15:0] d;
    logic ml, mh;
    len = cur_ws ? 1 : cur_bl;
    for (int k = 0; k < len; k++) begin
      d = 16'($urandom); ml = 1'($urandom); mh = 1'($urandom);
      model_wr(maddr(ba, row, colseq(col, k)), d, ml, mh);
      if (k == 0) drive(C_WR, 2'(ba), 13'((int'(ap) << 10) | col), ml, mh, d);
      else        drive(C_NOP, 2'd0, 13'd0, ml, mh, d);
    end
    nop(2);
  endtask

  task automatic txn();
    int ba, row, col;
    bit ap;
    ba = $urandom_range(0, 3); row = $urandom_range(0, 1);
    col = $urandom_range(0, 15); ap = 1'($urandom);
    drive(C_ACT, 2'(ba), 13'(row), 1'b0, 1'b0, 16'd0);
    nop($urandom_range(1, 3));
    if ($urandom_range(0, 1) == 1) do_write(ba, row, col, ap);
    else                           do_read(ba, row, col, ap, 1'b1);
    if (!ap) drive(C_PRE, 2'(ba), 13'(int'($urandom_range(0, 1)) << 10), 1'b0, 1'b0, 16'd0);
  endtask

  // Monitor: every cycle, compare the bus against the scoreboard head.
  always @(negedge clk) begin : monitor
    int  t;
    bit  due;
    bit  m;
    if (mon_en) begin
      t   = edge_n + 1;
      due = (expq.size() > 0) && (expq[0].due == t);
      m   = mask_at.exists(t);
      if (due && !m) begin
        chk("read_oe", {31'd0, dq_oe}, 32'd1);
        chk("read_data", {16'd0, dq_out}, {16'd0, expq[0].data});
      end else begin
        chk(due ? "masked_oe" : "idle_oe", {31'd0, dq_oe}, 32'd0);
      end
      if (due) void'(expq.pop_front());
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "timeout");
  end

  initial begin : stim
    @(negedge clk);
    nop(2);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_refresh", {16'd0, refresh_cnt}, 32'd0);
    chk("rst_oe", {31'd0, dq_oe}, 32'd0);
    chk("rst_dq_out", {16'd0, dq_out}, 32'd0);
    reset_n = 1'b1;
    nop(1);
    mon_en = 1'b1;

    // Refresh counting and refresh with a bank open.
    lmr(0, 2, 1'b1);
    repeat (8) drive(C_REF, 2'd0, 13'd0, 1'b0, 1'b0, 16'd0);
    chk("refresh_8", {16'd0, refresh_cnt}, 32'd8);
    chk("refresh_err0", {31'd0, err}, 32'd0);
    drive(C_ACT, 2'd0, 13'd0, 1'b0, 1'b0, 16'd0);
    drive(C_REF, 2'd0, 13'd0, 1'b0, 1'b0, 16'd0);
    chk("refresh_active_cnt", {16'd0, refresh_cnt}, 32'd8);
    chk("refresh_active_err", {31'd0, err}, 32'd1);
    pulse_reset();

    // READ before any LOAD_MODE.
    drive(C_RD, 2'd0, 13'd0, 1'b0, 1'b0, 16'd0);
    nop(3);
    chk("no_mode_err", {31'd0, err}, 32'd1);
    pulse_reset();

    // Basic write/read and byte-masked write.
    lmr(0, 2, 1'b1);
    drive(C_ACT, 2'd1, 13'd5, 1'b0, 1'b0, 16'd0);
    nop(1);
    drive(C_WR, 2'd1, 13'd3, 1'b0, 1'b0, 16'hBEEF);
    nop(1);
    expq.push_back('{edge_n + 3, 16'hBEEF});
    drive(C_RD, 2'd1, 13'd3, 1'b0, 1'b0, 16'd0);
    nop(3);
    chk("basic_err", {31'd0, err}, 32'd0);
    drive(C_WR, 2'd1, 13'd4, 1'b0, 1'b0, 16'hFFFF);
    nop(1);
    drive(C_WR, 2'd1, 13'd4, 1'b0, 1'b1, 16'h1234);
    nop(1);
    expq.push_back('{edge_n + 3, 16'hFF34});
    drive(C_RD, 2'd1, 13'd4, 1'b0, 1'b0, 16'd0);
    nop(3);
    drive(C_PRE, 2'd0, 13'h0400, 1'b0, 1'b0, 16'd0);

    // Prefill bank 0 rows 0..1, columns 0..15.
    for (int r = 0; r < 2; r++) begin
      drive(C_ACT, 2'd0, 13'(r), 1'b0, 1'b0, 16'd0);
      nop(1);
      for (int c = 0; c < 16; c++) begin
        logic [15:0] d;
        d = 16'($urandom);
        model_wr(maddr(0, r, c), d, 1'b0, 1'b0);
        drive(C_WR, 2'd0, 13'(c), 1'b0, 1'b0, d);
      end
      drive(C_PRE, 2'd0, 13'd0, 1'b0, 1'b0, 16'd0);
    end

    // BL4 CL3 wrapped read from column 6.
    lmr(2, 3, 1'b0);
    drive(C_ACT, 2'd0, 13'd0, 1'b0, 1'b0, 16'd0);
    nop(1);
    do_read(0, 0, 6, 1'b0, 1'b0);
    drive(C_PRE, 2'd0, 13'h0400, 1'b0, 1'b0, 16'd0);

    // Burst terminate right after a BL4 read: only the first word emits.
    lmr(2, 2, 1'b0);
    drive(C_ACT, 2'd0, 13'd1, 1'b0, 1'b0, 16'd0);
    nop(1);
    expq.push_back('{edge_n + 3, mm[maddr(0, 1, 2)]});
    drive(C_RD, 2'd0, 13'd2, 1'b0, 1'b0, 16'd0);
    drive(C_BT, 2'd0, 13'd0, 1'b0, 1'b0, 16'd0);
    nop(5);
    chk("bt_err", {31'd0, err}, 32'd0);
    drive(C_PRE, 2'd0, 13'h0400, 1'b0, 1'b0, 16'd0);

    // Randomized bursts under random modes.
    for (int g = 0; g < 6; g++) begin
      lmr($urandom_range(0, 3), $urandom_range(2, 3), 1'($urandom));
      repeat (10) txn();
      nop(4);
      chk("group_err", {31'd0, err}, 32'd0);
    end

    // Invalid burst-length code: err set, previous mode kept.
    drive(C_LMR, 2'd0, 13'h0024, 1'b0, 1'b0, 16'd0);
    chk("bad_lmr_err", {31'd0, err}, 32'd1);
    drive(C_ACT, 2'd0, 13'd0, 1'b0, 1'b0, 16'd0);
    nop(1);
    do_read(0, 0, 9, 1'b0, 1'b0);
    drive(C_PRE, 2'd0, 13'h0400, 1'b0, 1'b0, 16'd0);
    pulse_reset();

    // READ one cycle after ACTIVE violates tRCD.
    lmr(0, 2, 1'b1);
    drive(C_ACT, 2'd2, 13'd0, 1'b0, 1'b0, 16'd0);
    drive(C_RD, 2'd2, 13'd0, 1'b0, 1'b0, 16'd0);
    nop(4);
    chk("trcd_err", {31'd0, err}, 32'd1);
    pulse_reset();

    // LOAD_MODE with a bank open is rejected.
    lmr(0, 2, 1'b1);
    drive(C_ACT, 2'd3, 13'd0, 1'b0, 1'b0, 16'd0);
    drive(C_LMR, 2'd0, 13'h0032, 1'b0, 1'b0, 16'd0);
    chk("lmr_active_err", {31'd0, err}, 32'd1);
    do_read(3, 0, 5, 1'b1, 1'b0);
    pulse_reset();

    // Asynchronous reset in the middle of a BL8 read.
    lmr(3, 2, 1'b0);
    drive(C_ACT, 2'd0, 13'd0, 1'b0, 1'b0, 16'd0);
    nop(1);
    for (int k = 0; k < 8; k++)
      expq.push_back('{edge_n + 3 + k, mm[maddr(0, 0, k)]});
    drive(C_RD, 2'd0, 13'd0, 1'b0, 1'b0, 16'd0);
    nop(3);
    mon_en = 1'b0;
    chk("pre_reset_oe", {31'd0, dq_oe}, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_reset_oe", {31'd0, dq_oe}, 32'd0);
    expq.delete();
    @(negedge clk);
    reset_n = 1'b1;
    nop(3);
    chk("after_reset_oe", {31'd0, dq_oe}, 32'd0);
    chk("scoreboard_empty", 32'(expq.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
